// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel row readout path: FSM state encoding,
// the pixel word type, and the index-width helper used for port sizing.
package pixel_readout_pkg;

  // Readout sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One pixel sample as driven by a row's DATA_OUT lane.
  typedef logic [7:0] pixel_t;

  // Width of an index into n items; never narrower than one bit so that
  // single-row or single-column arrays still get a (constant 0) port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// Line buffer holding one captured row. The whole row bus is loaded in
// parallel on load_i; a pixel is selected combinationally by column so the
// streamed value follows the column counter with no extra latency.
module pixel_line_buffer
  import pixel_readout_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  pixel_t [WIDTH-1:0]       row_i,
  input  logic [idx_w(WIDTH)-1:0]  col_i,
  output pixel_t                   pixel_o
);

  pixel_t [WIDTH-1:0] buf_q;

  // Parallel load of the full row; contents persist until the next capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= row_i;
    end
  end

  assign pixel_o = buf_q[col_i];

endmodule

// File: rtl/pixel_row_reader.sv
// Frame readout sequencer. Walks the rows with a one-hot READ enable,
// lets each row settle, captures its bus into the line buffer and then
// streams the pixels out over valid/ready tagged with row and column.
module pixel_row_reader
  import pixel_readout_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int READ_SETTLE        = 2
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   START,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]          READ_ROW,
  input  pixel_t [PIXEL_ARRAY_WIDTH-1:0]         ROW_DATA,
  output pixel_t                                 PIXEL_DATA,
  output logic [idx_w(PIXEL_ARRAY_HEIGHT)-1:0]   PIXEL_ROW,
  output logic [idx_w(PIXEL_ARRAY_WIDTH)-1:0]    PIXEL_COL,
  output logic                                   PIXEL_VALID,
  input  logic                                   PIXEL_READY,
  output logic                                   BUSY,
  output logic                                   FRAME_DONE
);

  localparam int W  = PIXEL_ARRAY_WIDTH;
  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int RW = idx_w(H);
  localparam int CW = idx_w(W);

  localparam logic [RW-1:0] ROW_LAST    = RW'(H - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(W - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(READ_SETTLE - 1);

  state_t          state_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [3:0]      settle_q;
  logic [H-1:0]    read_row_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  logic            capture_en;
  logic            handshake;

  assign capture_en = (state_q == CAPTURE);
  assign handshake  = valid_q && PIXEL_READY;

  pixel_line_buffer #(
    .WIDTH (W)
  ) u_line_buffer (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (capture_en),
    .row_i   (ROW_DATA),
    .col_i   (col_q),
    .pixel_o (PIXEL_DATA)
  );

  // Sequencer: state, counters and all registered outputs in one place.
  // The first READ cycle of a frame only arms the enable; later rows get
  // their enable on the same edge as the final handshake of the prior row,
  // which keeps the per-row gap at READ_SETTLE+1 cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      settle_q   <= '0;
      read_row_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q  <= READ;
            row_q    <= '0;
            col_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
        end

        READ: begin
          if (read_row_q == '0) begin
            read_row_q <= H'(1) << row_q;
          end else if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state_q  <= CAPTURE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end

        CAPTURE: begin
          read_row_q <= '0;
          col_q      <= '0;
          valid_q    <= 1'b1;
          state_q    <= STREAM;
        end

        STREAM: begin
          if (handshake) begin
            if (col_q != COL_LAST) begin
              col_q <= col_q + 1'b1;
            end else begin
              valid_q <= 1'b0;
              col_q   <= '0;
              if (row_q != ROW_LAST) begin
                row_q      <= row_q + 1'b1;
                read_row_q <= H'(1) << (row_q + 1'b1);
                state_q    <= READ;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end

        DONE: begin
          row_q   <= '0;
          state_q <= IDLE;
        end

        default: begin
          state_q    <= IDLE;
          read_row_q <= '0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign READ_ROW    = read_row_q;
  assign PIXEL_ROW   = row_q;
  assign PIXEL_COL   = col_q;
  assign PIXEL_VALID = valid_q;
  assign BUSY        = busy_q;
  assign FRAME_DONE  = done_q;

endmodule

// File: tb/tb_pixel_row_reader.sv
// Scoreboard bench: stimulus pushes expected pixels / READ runs into queues,
// independent monitors pop and compare on each handshake.
module tb_pixel_row_reader;

  localparam int SA = 2;

  logic CLK = 1'b0;
  logic RESET;
  logic START_a, START_b;
  logic READY_a, READY_b;

  logic [1:0]      READ_ROW_a;
  logic [1:0][7:0] ROW_DATA_a;
  logic [7:0]      PIXEL_DATA_a;
  logic [0:0]      PIXEL_ROW_a, PIXEL_COL_a;
  logic            PIXEL_VALID_a, BUSY_a, FRAME_DONE_a;

  logic [0:0]      READ_ROW_b;
  logic [3:0][7:0] ROW_DATA_b;
  logic [7:0]      PIXEL_DATA_b;
  logic [0:0]      PIXEL_ROW_b;
  logic [1:0]      PIXEL_COL_b;
  logic            PIXEL_VALID_b, BUSY_b, FRAME_DONE_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int done_cyc_a = 0, done_cyc_b = 0;
  int b_hs_cnt = 0, last_b = 0;
  bit garbage = 0;

  logic [15:0] row_val [2];
  logic [23:0] exp_a [$];
  logic [23:0] exp_b [$];
  logic [1:0]  exp_rr_a [$];

  logic [23:0] pix_a, pix_b;
  assign pix_a = {8'(PIXEL_ROW_a), 8'(PIXEL_COL_a), PIXEL_DATA_a};
  assign pix_b = {8'(PIXEL_ROW_b), 8'(PIXEL_COL_b), PIXEL_DATA_b};

  pixel_row_reader #(
    .PIXEL_ARRAY_WIDTH(2), .PIXEL_ARRAY_HEIGHT(2), .READ_SETTLE(SA)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .START(START_a), .READ_ROW(READ_ROW_a),
    .ROW_DATA(ROW_DATA_a), .PIXEL_DATA(PIXEL_DATA_a), .PIXEL_ROW(PIXEL_ROW_a),
    .PIXEL_COL(PIXEL_COL_a), .PIXEL_VALID(PIXEL_VALID_a), .PIXEL_READY(READY_a),
    .BUSY(BUSY_a), .FRAME_DONE(FRAME_DONE_a)
  );

  pixel_row_reader #(
    .PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(1), .READ_SETTLE(1)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .START(START_b), .READ_ROW(READ_ROW_b),
    .ROW_DATA(ROW_DATA_b), .PIXEL_DATA(PIXEL_DATA_b), .PIXEL_ROW(PIXEL_ROW_b),
    .PIXEL_COL(PIXEL_COL_b), .PIXEL_VALID(PIXEL_VALID_b), .PIXEL_READY(READY_b),
    .BUSY(BUSY_b), .FRAME_DONE(FRAME_DONE_b)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic fail_timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: actual=timeout required=event", nm);
  endtask

  // Pixel array model for DUT A: presents the selected row's bus while READ
  // is high; in garbage mode only the CAPTURE cycle (READ age SA+1) is real.
  initial begin
    int rr_age;
    rr_age = 0;
    ROW_DATA_a = '0;
    forever begin
      @(posedge CLK); #1;
      if (READ_ROW_a != 2'b00) rr_age++; else rr_age = 0;
      if (READ_ROW_a != 2'b00 && (!garbage || rr_age == SA + 1))
        ROW_DATA_a = READ_ROW_a[1] ? row_val[1] : row_val[0];
      else
        ROW_DATA_a = garbage ? 16'($urandom) : 16'h0000;
    end
  end

  // Monitor for DUT A: pixels, backpressure hold, READ runs, FRAME_DONE.
  initial begin
    bit prev_stall;
    logic [23:0] prev_pix;
    int rr_run;
    logic [1:0] rr_val, rr_exp;
    prev_stall = 0; prev_pix = '0; rr_run = 0; rr_val = '0;
    forever begin
      @(negedge CLK);
      if (FRAME_DONE_a) begin done_cnt_a++; done_cyc_a = cyc; end
      if (!RESET && prev_stall) begin
        chk("hold_valid", 32'(PIXEL_VALID_a), 32'd1);
        chk("hold_pixel", 32'(pix_a), 32'(prev_pix));
      end
      prev_stall = !RESET && PIXEL_VALID_a && !READY_a;
      prev_pix = pix_a;
      if (PIXEL_VALID_a && READY_a) begin
        if (exp_a.size() == 0) begin
          total_cnt++;
          $display("FAIL a_pixel: actual=%h required=none", pix_a);
        end else begin
          chk("a_pixel", 32'(pix_a), 32'(exp_a.pop_front()));
        end
      end
      if (RESET) begin
        rr_run = 0;
      end else if (READ_ROW_a != 2'b00) begin
        if (rr_run == 0) rr_val = READ_ROW_a;
        else chk("rr_stable", 32'(READ_ROW_a), 32'(rr_val));
        rr_run++;
      end else if (rr_run != 0) begin
        if (exp_rr_a.size() == 0) begin
          total_cnt++;
          $display("FAIL rr_run: actual=%0h required=none", rr_val);
        end else begin
          rr_exp = exp_rr_a.pop_front();
          chk("rr_value", 32'(rr_val), 32'(rr_exp));
          chk("rr_length", 32'(rr_run), 32'(SA + 1));
        end
        rr_run = 0;
      end
    end
  end

  // Monitor for DUT B: pixels, back-to-back handshakes, FRAME_DONE.
  initial begin
    forever begin
      @(negedge CLK);
      if (FRAME_DONE_b) begin done_cnt_b++; done_cyc_b = cyc; end
      if (PIXEL_VALID_b && READY_b) begin
        if (exp_b.size() == 0) begin
          total_cnt++;
          $display("FAIL b_pixel: actual=%h required=none", pix_b);
        end else begin
          chk("b_pixel", 32'(pix_b), 32'(exp_b.pop_front()));
        end
        if (b_hs_cnt > 0) chk("b_consecutive", 32'(cyc - last_b), 32'd1);
        last_b = cyc;
        b_hs_cnt++;
      end
    end
  end

  task automatic load_frame(input logic [15:0] r0, input logic [15:0] r1);
    row_val[0] = r0;
    row_val[1] = r1;
    exp_a.push_back({8'd0, 8'd0, r0[7:0]});
    exp_a.push_back({8'd0, 8'd1, r0[15:8]});
    exp_a.push_back({8'd1, 8'd0, r1[7:0]});
    exp_a.push_back({8'd1, 8'd1, r1[15:8]});
    exp_rr_a.push_back(2'b01);
    exp_rr_a.push_back(2'b10);
  endtask

  task automatic start_frame(input bit is_b, output int s);
    @(posedge CLK); #1;
    if (is_b) START_b = 1'b1; else START_a = 1'b1;
    @(posedge CLK); #1;
    s = cyc;
    START_a = 1'b0;
    START_b = 1'b0;
  endtask

  task automatic wait_done(input bit is_b, input string nm);
    int base;
    base = is_b ? done_cnt_b : done_cnt_a;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK); #1;
      if ((is_b ? done_cnt_b : done_cnt_a) != base) return;
    end
    fail_timeout(nm);
  endtask

  task automatic wait_valid_a(input string nm);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (PIXEL_VALID_a) return;
    end
    fail_timeout(nm);
  endtask

  task automatic wait_rr_a(input logic [1:0] v, input string nm);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (READ_ROW_a == v) return;
    end
    fail_timeout(nm);
  endtask

  initial begin
    int s, d0;
    RESET = 1'b1; START_a = 1'b0; START_b = 1'b0;
    READY_a = 1'b1; READY_b = 1'b1;
    row_val[0] = '0; row_val[1] = '0;
    ROW_DATA_b = 32'hA0B1C2D3;
    repeat (2) @(posedge CLK); #1;

    chk("rst_read_row", 32'(READ_ROW_a), 32'd0);
    chk("rst_valid", 32'(PIXEL_VALID_a), 32'd0);
    chk("rst_pixel", 32'(pix_a), 32'd0);
    chk("rst_busy", 32'(BUSY_a), 32'd0);
    chk("rst_done", 32'(FRAME_DONE_a), 32'd0);
    chk("rst_b_valid", 32'(PIXEL_VALID_b), 32'd0);
    RESET = 1'b0;

    // 1: basic frame, first-pixel latency and frame length
    load_frame(16'h1122, 16'h3344);
    d0 = done_cnt_a;
    start_frame(0, s);
    chk("t1_busy", 32'(BUSY_a), 32'd1);
    wait_valid_a("t1_first_valid");
    chk("t1_latency", 32'(cyc - s), 32'(SA + 2));
    wait_done(0, "t1_done");
    chk("t1_frame_len", 32'(done_cyc_a - s + 1), 32'd12);
    chk("t1_busy_at_done", 32'(BUSY_a), 32'd0);
    chk("t1_done_count", 32'(done_cnt_a - d0), 32'd1);
    chk("t1_queue_empty", 32'(exp_a.size()), 32'd0);
    @(posedge CLK); #1;
    chk("t1_done_pulse", 32'(FRAME_DONE_a), 32'd0);

    // 2: five stalled cycles on the first pixel
    READY_a = 1'b0;
    load_frame(16'h1122, 16'h3344);
    start_frame(0, s);
    wait_valid_a("t2_first_valid");
    chk("t2_stall_pixel", 32'(pix_a), 32'h000022);
    repeat (5) begin @(posedge CLK); #1; end
    READY_a = 1'b1;
    wait_done(0, "t2_done");
    chk("t2_frame_len", 32'(done_cyc_a - s + 1), 32'd17);
    chk("t2_queue_empty", 32'(exp_a.size()), 32'd0);

    // 3: START during STREAM is ignored
    load_frame(16'h6677, 16'h8899);
    d0 = done_cnt_a;
    start_frame(0, s);
    wait_valid_a("t3_first_valid");
    START_a = 1'b1;
    @(posedge CLK); #1;
    START_a = 1'b0;
    wait_done(0, "t3_done");
    chk("t3_frame_len", 32'(done_cyc_a - s + 1), 32'd12);
    chk("t3_done_count", 32'(done_cnt_a - d0), 32'd1);

    // 4: back-to-back START after FRAME_DONE; bus only valid in CAPTURE
    garbage = 1;
    load_frame(16'h5AA5, 16'hC33C);
    start_frame(0, s);
    wait_done(0, "t4_done");
    chk("t4_frame_len", 32'(done_cyc_a - s + 1), 32'd12);
    chk("t4_done_count", 32'(done_cnt_a - d0), 32'd2);
    chk("t4_queue_empty", 32'(exp_a.size()), 32'd0);
    garbage = 0;

    // 5: asynchronous reset while row 1 is being read
    load_frame(16'h0102, 16'h0304);
    start_frame(0, s);
    wait_rr_a(2'b10, "t5_row1_read");
    @(posedge CLK); #3;
    RESET = 1'b1;
    exp_a.delete();
    exp_rr_a.delete();
    #1;
    chk("t5_read_row", 32'(READ_ROW_a), 32'd0);
    chk("t5_valid", 32'(PIXEL_VALID_a), 32'd0);
    chk("t5_busy", 32'(BUSY_a), 32'd0);
    d0 = done_cnt_a;
    repeat (3) begin @(posedge CLK); #1; end
    RESET = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    chk("t5_no_done", 32'(done_cnt_a - d0), 32'd0);
    chk("t5_idle", 32'(BUSY_a), 32'd0);
    load_frame(16'hABCD, 16'hEF01);
    start_frame(0, s);
    wait_done(0, "t5_restart_done");
    chk("t5_frame_len", 32'(done_cyc_a - s + 1), 32'd12);
    chk("t5_queue_empty", 32'(exp_a.size()), 32'd0);

    // 6: W=4, H=1, SETTLE=1
    exp_b.push_back(24'h0000D3);
    exp_b.push_back(24'h0001C2);
    exp_b.push_back(24'h0002B1);
    exp_b.push_back(24'h0003A0);
    b_hs_cnt = 0;
    start_frame(1, s);
    wait_done(1, "t6_done");
    chk("t6_frame_len", 32'(done_cyc_b - s + 1), 32'd8);
    chk("t6_handshakes", 32'(b_hs_cnt), 32'd4);
    chk("t6_queue_empty", 32'(exp_b.size()), 32'd0);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pixel_row_reader.md
Name: pixel_row_reader

Overview:
Readout-side counterpart of the pixel row. It sequences one-hot READ enables across PIXEL_ARRAY_HEIGHT rows and holds each READ for a settle window. It then captures that row's PIXEL_ARRAY_WIDTH x 8-bit DATA_OUT bus into a line buffer and streams the pixels out one at a time over a valid/ready handshake, tagged with row and column. It sits between the pixel array and the downstream frame/output logic and is the only driver of the rows' READ inputs.

Parameters:
PIXEL_ARRAY_WIDTH, 2, pixels per row (bus width W).
PIXEL_ARRAY_HEIGHT, 2, rows in the array (H).
READ_SETTLE, 2, cycles READ is held before the row bus is sampled; legal range 1..15.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  one-cycle pulse; begins a frame readout when idle.
READ_ROW  output  H  one-hot READ enable, one bit per row.
ROW_DATA  input  [W-1:0][7:0]  DATA_OUT bus of the currently read row.
PIXEL_DATA  output  8  streamed pixel value.
PIXEL_ROW  output  max(1,$clog2(H))  row index of PIXEL_DATA.
PIXEL_COL  output  max(1,$clog2(W))  column index of PIXEL_DATA.
PIXEL_VALID  output  1  PIXEL_DATA/ROW/COL are valid.
PIXEL_READY  input  1  downstream accepts when high with PIXEL_VALID.
BUSY  output  1  high from accepted START until the cycle FRAME_DONE pulses.
FRAME_DONE  output  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; READ_ROW=0; PIXEL_VALID=0; PIXEL_DATA=0; PIXEL_ROW=0; PIXEL_COL=0; BUSY=0; FRAME_DONE=0; row, column and settle counters=0. Reset mid-frame abandons the frame with no FRAME_DONE, and READ_ROW drops without waiting for a clock.
- FSM states: IDLE, READ, CAPTURE, STREAM, DONE.
- IDLE: on START=1 go to READ with row=0 and BUSY=1. START in any other state is ignored and is not queued.
- READ: READ_ROW[row]=1, all other bits 0. The settle counter counts READ_SETTLE cycles, then the FSM goes to CAPTURE. READ_ROW bit is high for exactly READ_SETTLE+1 cycles, including the CAPTURE cycle.
- CAPTURE: on the clock edge leaving CAPTURE, ROW_DATA is registered into the line buffer. READ_ROW goes to 0 on the next cycle. Go to STREAM with col=0.
- STREAM: PIXEL_VALID=1, PIXEL_DATA=buffer[col], PIXEL_ROW=row, PIXEL_COL=col. A handshake occurs on a cycle with VALID&READY.
  - While READY=0: data, indices and VALID are held stable; VALID never drops without a handshake.
  - Handshake with col<W-1: col increments and the next pixel is presented the following cycle.
  - Handshake with col=W-1 and row<H-1: row increments, VALID drops, go to READ.
  - Handshake with col=W-1 and row=H-1: go to DONE.
- DONE: FRAME_DONE=1 and BUSY=0 for one cycle, then IDLE.
- Throughput: with READY held high, one pixel per cycle within a row. Per-row overhead is READ_SETTLE+1 cycles with no VALID.
- First-pixel latency: START sampled at edge 0 gives PIXEL_VALID high after edge READ_SETTLE+2.
- Frame length with READY=1: 1 + H*(READ_SETTLE+1+W) + 1 cycles from START edge to the FRAME_DONE cycle inclusive.
- ROW_DATA is sampled only in CAPTURE; its value in all other cycles is don't-care.
- Counters wrap only through explicit reset to 0; indices never exceed W-1/H-1.
- H=1 or W=1 are legal; the index ports are then 1 bit, constant 0.

Decomposition:
- Shared package pixel_readout_pkg holds:
  - the state enum typedef (IDLE, READ, CAPTURE, STREAM, DONE);
  - the pixel_t 8-bit typedef;
  - a localparam function for index width, max(1,$clog2(n)).
- One natural sub-module, pixel_line_buffer: a W x 8 register array with a parallel load enable and a combinational read mux by col. The FSM, counters and handshake stay in pixel_row_reader.

Test Plan:
1. W=2, H=2, SETTLE=2, READY=1. Row0 bus={0x11,0x22}, row1 bus={0x33,0x44}, START pulse.
   Required: READ_ROW=01 for 3 cycles, then pixels (r0,c0,0x22),(r0,c1,0x11); READ_ROW=10 for 3 cycles, then (r1,c0,0x44),(r1,c1,0x33); FRAME_DONE one cycle later; 12 cycles total.
2. Backpressure: same frame with READY=0 for 5 cycles while the first pixel is valid.
   Required: VALID, DATA=0x22 and COL=0 held stable for those cycles; no pixel skipped or duplicated; the 4 handshakes arrive in the same order.
3. START re-pulsed during STREAM.
   Required: ignored, exactly one FRAME_DONE, frame length unchanged; a START on the cycle after FRAME_DONE begins a new frame.
4. ROW_DATA changed on every cycle except CAPTURE.
   Required: the streamed values equal only the CAPTURE-cycle values.
5. RESET asserted asynchronously mid-READ of row1.
   Required: READ_ROW=00, VALID=0, BUSY=0 before the next edge; no FRAME_DONE; the next START restarts at row0.
6. W=4, H=1, SETTLE=1, READY=1, bus={0xA0,0xB1,0xC2,0xD3}.
   Required: columns 0..3 stream 0xD3,0xC2,0xB1,0xA0 on consecutive cycles; PIXEL_ROW=0 throughout; FRAME_DONE after 8 cycles total.
